// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single processor memory interface (pmi) between the instruction
//   fetch requester (IF, read-only) and the data load/store requester (D).
//   One access at a time: IDLE (arbitrate) -> ACCESS (strobe until mfc or
//   timeout) -> DONE (one-cycle done pulse) -> IDLE. D normally wins. Once D
//   has won STARVE times in a row while IF was waiting, a pending IF wins next.
//
// Ports
//   clk_i, rst_i               clock (rising edge), async active-high reset
//   if_req_i, if_addr_i        IF read request (held until if_done_o) / address
//   if_gnt_o, if_done_o        IF owns the pmi / one-cycle completion pulse
//   if_rdata_o                 IF read data, valid with if_done_o, then held
//   d_req_i, d_we_i            D request (held until d_done_o) / 1=store 0=load
//   d_addr_i, d_wdata_i        D address / store data
//   d_gnt_o, d_done_o          D owns the pmi / one-cycle completion pulse
//   d_rdata_o                  D load data, valid with d_done_o, then held
//   mem_ad_o, mem_wdata_o      address / store data to the pmi
//   mem_rd_o, mem_wr_o         read / write strobes to the pmi
//   mem_rdata_i, mfc_i         read data from the pmi / completion pulse
//   err_o                      pulses with done when the access timed out
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int STARVE  = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_done_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_done_o,
  output logic [DW-1:0] d_rdata_o,
  output logic [AW-1:0] mem_ad_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_rd_o,
  output logic          mem_wr_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mfc_i,
  output logic          err_o
);

  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int SCW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             owner_d_q, owner_d_d;   // 1 = D owns the access, 0 = IF
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [TCW-1:0]   tcnt_q, tcnt_d;
  logic [SCW-1:0]   starve_q, starve_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic             if_gnt_q, if_gnt_d;
  logic             d_gnt_q, d_gnt_d;
  logic             if_done_q, if_done_d;
  logic             d_done_q, d_done_d;
  logic             err_q, err_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic [DW-1:0]    d_rdata_q, d_rdata_d;
  logic             if_wins_s;

  // IF wins when it is the only requester or when D has starved it long enough.
  always_comb begin
    if (if_req_i && (!d_req_i || (starve_q == SCW'(STARVE)))) begin
      if_wins_s = 1'b1;
    end else begin
      if_wins_s = 1'b0;
    end
  end

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d    = state_q;
    owner_d_d  = owner_d_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tcnt_d     = tcnt_q;
    starve_d   = starve_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    if_gnt_d   = if_gnt_q;
    d_gnt_d    = d_gnt_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        tcnt_d   = '0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        if_gnt_d = 1'b0;
        d_gnt_d  = 1'b0;
        if (if_req_i || d_req_i) begin
          state_d = ST_ACCESS;
          if (if_wins_s) begin
            owner_d_d = 1'b0;
            we_d      = 1'b0;
            addr_d    = if_addr_i;
            if_gnt_d  = 1'b1;
            mem_rd_d  = 1'b1;
            starve_d  = '0;
          end else begin
            owner_d_d = 1'b1;
            we_d      = d_we_i;
            addr_d    = d_addr_i;
            wdata_d   = d_wdata_i;
            d_gnt_d   = 1'b1;
            mem_rd_d  = ~d_we_i;
            mem_wr_d  = d_we_i;
            // Only count wins that actually made IF wait; saturate at STARVE.
            if (if_req_i && (starve_q != SCW'(STARVE))) begin
              starve_d = starve_q + SCW'(1);
            end else begin
              starve_d = starve_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        tcnt_d = tcnt_q + TCW'(1);
        if (mfc_i) begin
          state_d  = ST_DONE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (owner_d_q) begin
            d_done_d = 1'b1;
            // A store leaves the previous load data visible.
            if (!we_q) begin
              d_rdata_d = mem_rdata_i;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th strobe cycle with no mfc: abort.
          state_d  = ST_DONE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          err_d    = 1'b1;
          if (owner_d_q) begin
            d_done_d = 1'b1;
          end else begin
            if_done_d = 1'b1;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end

      ST_DONE: begin
        // Grant is released here so IDLE is a dead cycle before the next grant.
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        if_gnt_d = 1'b0;
        d_gnt_d  = 1'b0;
      end

      default: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        if_gnt_d = 1'b0;
        d_gnt_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops strobes and grants asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_d_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tcnt_q     <= '0;
      starve_q   <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_d_q  <= owner_d_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tcnt_q     <= tcnt_d;
      starve_q   <= starve_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      if_gnt_q   <= if_gnt_d;
      d_gnt_q    <= d_gnt_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_gnt_o    = if_gnt_q;
  assign if_done_o   = if_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_gnt_o     = d_gnt_q;
  assign d_done_o    = d_done_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_ad_o    = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Transaction-level bench for mem_arbiter. Each round starts with the arbiter
//   idle; the reference model picks the winner from the pending requests and
//   the starvation count, and pushes the expected completion (owner, err,
//   read data, completion cycle) onto a scoreboard. The bench plays the pmi,
//   returning mfc after a chosen delay (or never, to force a timeout). A
//   separate monitor pops the scoreboard whenever a done pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_done;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_done;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] mem_ad;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rd, mem_wr, mfc, err;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .STARVE(ST)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_done_o(if_done), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_done_o(d_done), .d_rdata_o(d_rdata),
    .mem_ad_o(mem_ad), .mem_wdata_o(mem_wdata), .mem_rd_o(mem_rd),
    .mem_wr_o(mem_wr), .mem_rdata_i(mem_rdata), .mfc_i(mfc), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            own_d;
    bit            err;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  bit   act_log[$];     // owner of each observed done, 1 = D
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int            starve_m;
  logic [DW-1:0] if_rd_m, d_rd_m;

  // Requester state (what each requester currently wants)
  bit            if_pend, d_pend, d_we_r;
  logic [AW-1:0] if_a, d_a;
  logic [DW-1:0] d_wd;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  exp_t mon_e;
  always @(negedge clk) begin
    check("gnt_exclusive", {255'd0, if_gnt & d_gnt}, 256'd0);
    if (if_done || d_done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: if_done=%0b d_done=%0b with nothing expected (cycle %0d)",
                 if_done, d_done, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        act_log.push_back(d_done);
        check("done_single", {255'd0, if_done & d_done}, 256'd0);
        check("done_owner", {255'd0, d_done}, {255'd0, mon_e.own_d});
        check("done_cycle", 256'(cyc), 256'(mon_e.cyc));
        check("done_err", {255'd0, err}, {255'd0, mon_e.err});
        if (mon_e.own_d) check("d_rdata", 256'(d_rdata), 256'(mon_e.rdata));
        else             check("if_rdata", 256'(if_rdata), 256'(mon_e.rdata));
      end
    end else begin
      check("err_without_done", {255'd0, err}, 256'd0);
    end
  end

  // Make sure at least one requester is pending, adding fresh random requests.
  task automatic refresh_requests();
    if (!if_pend && ($urandom_range(0, 1) == 1)) begin
      if_pend = 1'b1; if_a = $urandom;
    end
    if (!d_pend && ($urandom_range(0, 1) == 1)) begin
      d_pend = 1'b1; d_a = $urandom; d_wd = $urandom; d_we_r = 1'($urandom_range(0, 1));
    end
    if (!if_pend && !d_pend) begin
      d_pend = 1'b1; d_a = $urandom; d_wd = $urandom; d_we_r = 1'($urandom_range(0, 1));
    end
  endtask

  // One access. Entered one time unit after the edge that starts an idle cycle.
  // k = ACCESS cycle (1..TO) in which mfc pulses; k = 0 means no mfc (timeout).
  task automatic run_round(input int k, input logic [DW-1:0] rd, input bit stray_idle,
                           input bit stray_done, input bit drop_req);
    int            c0, kk;
    bit            win_if, timeout, exprd, expwr;
    logic [AW-1:0] expaddr;
    exp_t          e;
    c0 = cyc;
    check("idle_bus", {252'd0, if_gnt, d_gnt, mem_rd, mem_wr}, 256'd0);
    if_req = if_pend; if_addr = if_a;
    d_req = d_pend; d_we = d_we_r; d_addr = d_a; d_wdata = d_wd;
    mfc = stray_idle; mem_rdata = $urandom;

    win_if = if_pend && (!d_pend || (starve_m == ST));
    if (win_if) starve_m = 0;
    else if (if_pend && (starve_m < ST)) starve_m = starve_m + 1;
    timeout = (k == 0);
    kk = timeout ? TO : k;
    if (win_if) begin
      if (!timeout) if_rd_m = rd;
      e.rdata = if_rd_m;
    end else begin
      if (!timeout && !d_we_r) d_rd_m = rd;
      e.rdata = d_rd_m;
    end
    e.own_d = !win_if;
    e.err   = timeout;
    e.cyc   = c0 + kk + 1;
    sb_q.push_back(e);
    expaddr = win_if ? if_a : d_a;
    exprd   = win_if || !d_we_r;
    expwr   = !win_if && d_we_r;

    for (int j = 1; j <= kk; j++) begin
      @(posedge clk); #1;
      check("access_bus", {220'd0, if_gnt, d_gnt, mem_rd, mem_wr, mem_ad},
            {220'd0, win_if, !win_if, exprd, expwr, expaddr});
      if (expwr) check("mem_wdata", 256'(mem_wdata), 256'(d_wd));
      mfc = !timeout && (j == kk);
      mem_rdata = (j == kk) ? rd : $urandom;
      if (j == 1 && !win_if) begin
        // D inputs are only sampled at grant; wiggle them to prove it.
        d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
      end
      if (drop_req && j == 1) begin
        if (win_if) if_req = 1'b0;
        else        d_req  = 1'b0;
      end
    end
    if (win_if) if_pend = 1'b0;
    else        d_pend  = 1'b0;

    @(posedge clk); #1;
    check("done_bus", {252'd0, if_gnt, d_gnt, mem_rd, mem_wr}, {252'd0, win_if, !win_if, 2'b00});
    mfc = stray_done; mem_rdata = $urandom;
    @(posedge clk); #1;
    mfc = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mfc = 1'b0;
    starve_m = 0; if_rd_m = '0; d_rd_m = '0;
    if_pend = 1'b0; d_pend = 1'b0; d_we_r = 1'b0; if_a = '0; d_a = '0; d_wd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {121'd0, if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
                          mem_ad, mem_wdata, mem_rd, mem_wr, err}, 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // IF read of 0x100, mfc two cycles after mem_rd rises
    if_pend = 1'b1; if_a = 32'h0000_0100;
    run_round(3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check("if_rdata_held", 256'(if_rdata), 256'(32'hDEAD_BEEF));

    // D load to set d_rdata, then a store that must leave it untouched
    d_pend = 1'b1; d_a = 32'h0000_0040; d_we_r = 1'b0; d_wd = '0;
    run_round(1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    d_pend = 1'b1; d_a = 32'h0000_0020; d_we_r = 1'b1; d_wd = 32'h0000_55AA;
    run_round(2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check("d_rdata_after_store", 256'(d_rdata), 256'(32'h1234_5678));

    // Timeout, then a normal access
    if_pend = 1'b1; if_a = 32'h0000_0200;
    run_round(0, 32'h0, 1'b0, 1'b0, 1'b0);
    d_pend = 1'b1; d_a = 32'h0000_0300; d_we_r = 1'b0;
    run_round(4, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);

    // Reset mid-access: strobe drops at once, no done, pending request served after
    if_pend = 1'b1; if_a = 32'h0000_0400;
    if_req = 1'b1; if_addr = if_a; d_req = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_strobe", {255'd0, mem_rd}, {255'd0, 1'b1});
    #2 rst = 1'b1;
    #1;
    check("rst_async_drop", {253'd0, mem_rd, mem_wr, if_gnt}, 256'd0);
    starve_m = 0; if_rd_m = '0; d_rd_m = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata_clear", {192'd0, if_rdata, d_rdata}, 256'd0);
    rst = 1'b0;
    run_round(2, 32'h0BAD_CAFE, 1'b0, 1'b0, 1'b0);

    // Both requesters held high for six accesses: D,D,D,D,IF,D
    act_log.delete();
    for (int r = 0; r < 6; r++) begin
      if (!if_pend) begin if_pend = 1'b1; if_a = $urandom; end
      if (!d_pend) begin d_pend = 1'b1; d_a = $urandom; d_wd = $urandom; d_we_r = 1'($urandom_range(0, 1)); end
      run_round(1, $urandom, 1'b0, 1'b0, 1'b0);
    end
    check("starve_order_len", 256'(act_log.size()), 256'd6);
    if (act_log.size() == 6) begin
      check("starve_order", {250'd0, act_log[0], act_log[1], act_log[2], act_log[3],
                             act_log[4], act_log[5]}, {250'd0, 6'b111101});
    end

    // Stray mfc in IDLE and DONE, request dropped mid-access
    if (!d_pend) begin d_pend = 1'b1; d_a = 32'h0000_0500; d_we_r = 1'b0; end
    run_round(3, 32'hA5A5_5A5A, 1'b1, 1'b1, 1'b1);

    // Randomized traffic
    for (int r = 0; r < 40; r++) begin
      refresh_requests();
      k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
      run_round(k, $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 3) == 0));
    end

    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 256'(sb_q.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
